// File: rtl/vx_commit_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vx_commit_arb_pkg
// Description : Shared types and helpers for the commit arbiter. Holds the
//               commit beat struct, sizing constants and the closing-beat
//               predicate used by the arbiter and its users.
// Revision    : 1.0 - initial release
// ============================================================================
package vx_commit_arb_pkg;

  localparam int NUM_THREADS  = 2;
  localparam int NUM_LANES    = NUM_THREADS;
  localparam bit EXT_V_ENABLE = 1'b1;

  localparam int UUID_W = 8;
  localparam int NW_W   = 2;
  localparam int PC_W   = 32;
  localparam int NR_W   = 5;
  localparam int XLEN   = 32;
  localparam int PID_W  = 1;

  // One commit beat. The vector fields are only meaningful when
  // EXT_V_ENABLE is set; otherwise they are ignored by is_closing_beat().
  typedef struct packed {
    logic [UUID_W-1:0]              uuid;
    logic [NW_W-1:0]                wid;
    logic [NUM_LANES-1:0]           tmask;
    logic [PC_W-1:0]                pc;
    logic                           wb;
    logic [NR_W-1:0]                rd;
    logic [NUM_LANES-1:0][XLEN-1:0] data;
    logic [PID_W-1:0]               pid;
    logic                           sop;
    logic                           eop;
    logic                           is_vec;
    logic                           vd_is_last;
  } commit_data_t;

  // A beat closes its instruction when it is the last packet and, for vector
  // ops, also targets the last destination register of the group.
  function automatic logic is_closing_beat(input commit_data_t beat);
    return beat.eop && (!EXT_V_ENABLE || !beat.is_vec || beat.vd_is_last);
  endfunction

  // Index width that stays at least one bit wide for a single source.
  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vx_commit_arb_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : vx_commit_arb_rr_picker
// Description : Combinational round-robin find-first. Returns the first
//               asserted request at or after rr_ptr, scanning upward with
//               wrap-around.
// Ports       : req         in  NUM_REQS  request vector
//               rr_ptr      in  SEL_W     starting index of the scan
//               grant_idx   out SEL_W     index of the winning request
//               grant_valid out 1         at least one request asserted
// Revision    : 1.0 - initial release
// ============================================================================
module vx_commit_arb_rr_picker
  import vx_commit_arb_pkg::*;
#(
  parameter int NUM_REQS = 4,
  localparam int SEL_W   = log2up(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] req,
  input  logic [SEL_W-1:0]    rr_ptr,
  output logic [SEL_W-1:0]    grant_idx,
  output logic                grant_valid
);

  // Scanning from the farthest offset down to zero lets the closest
  // request to rr_ptr overwrite any earlier hit.
  always_comb begin : p_pick
    int idx;
    idx         = 0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQS) begin
        idx = idx - NUM_REQS;
      end
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = SEL_W'(idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vx_commit_arb.sv
`default_nettype none
// ============================================================================
// Module      : vx_commit_arb
// Description : Merges NUM_REQS commit streams into one registered commit
//               port. Round-robin between instructions; a grant is held from
//               the first beat until the closing beat so beats of one
//               instruction are never interleaved with another source.
// Ports       : clk          in  1                 clock
//               reset        in  1                 synchronous, active-low
//               in_valid     in  NUM_REQS          per-source beat valid
//               in_data      in  NUM_REQS x beat   per-source beat
//               in_ready     out NUM_REQS          per-source accept
//               out_valid    out 1                 registered beat valid
//               out_data     out beat              registered beat
//               out_ready    in  1                 downstream accept
//               out_sel      out SEL_W             source of out_data
//               locked       out 1                 transaction in progress
//               perf_stalls  out PERF_CTR_W        saturating stall cycles
// Revision    : 1.0 - initial release
// ============================================================================
module vx_commit_arb
  import vx_commit_arb_pkg::*;
#(
  parameter int NUM_REQS   = 4,
  parameter int PERF_CTR_W = 32,
  localparam int SEL_W     = log2up(NUM_REQS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQS-1:0]          in_valid,
  input  commit_data_t [NUM_REQS-1:0]  in_data,
  output logic [NUM_REQS-1:0]          in_ready,
  output logic                         out_valid,
  output commit_data_t                 out_data,
  input  logic                         out_ready,
  output logic [SEL_W-1:0]             out_sel,
  output logic                         locked,
  output logic [PERF_CTR_W-1:0]        perf_stalls
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]            r_state;
  logic [0:0]            w_state_next;
  logic [SEL_W-1:0]      r_lock_idx;
  logic [SEL_W-1:0]      r_rr_ptr;
  logic                  r_out_valid;
  commit_data_t          r_out_data;
  logic [SEL_W-1:0]      r_out_sel;
  logic [PERF_CTR_W-1:0] r_perf_stalls;

  logic                  w_load;
  logic [SEL_W-1:0]      w_pick_idx;
  logic                  w_pick_valid;
  logic [SEL_W-1:0]      w_grant_idx;
  logic                  w_grant_valid;
  logic                  w_grant_live;
  commit_data_t          w_grant_beat;
  logic                  w_closing;
  logic                  w_accept;
  logic [SEL_W-1:0]      w_ptr_next;

  // The output register can take a new beat when empty or draining.
  assign w_load = !r_out_valid || out_ready;

  vx_commit_arb_rr_picker #(
    .NUM_REQS (NUM_REQS)
  ) u_picker (
    .req         (in_valid),
    .rr_ptr      (r_rr_ptr),
    .grant_idx   (w_pick_idx),
    .grant_valid (w_pick_valid)
  );

  // While locked only the owning source is eligible, even during bubbles.
  always_comb begin
    w_grant_idx   = w_pick_idx;
    w_grant_valid = w_pick_valid;
    w_grant_live  = w_pick_valid;
    if (r_state == ST_LOCKED) begin
      w_grant_idx   = r_lock_idx;
      w_grant_valid = in_valid[r_lock_idx];
      w_grant_live  = 1'b1;
    end
  end

  assign w_grant_beat = in_data[w_grant_idx];
  assign w_closing    = is_closing_beat(w_grant_beat);
  assign w_accept     = reset && w_load && w_grant_valid;
  assign w_ptr_next   = (w_grant_idx == SEL_W'(NUM_REQS - 1)) ? '0 : w_grant_idx + 1'b1;

  // ---------------------------------------------------------------- FSM: state
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ----------------------------------------------------------- FSM: next state
  // A continuation beat (re)enters LOCKED; only a closing beat releases it.
  always_comb begin
    w_state_next = r_state;
    if (w_accept) begin
      w_state_next = w_closing ? ST_IDLE : ST_LOCKED;
    end
  end

  // --------------------------------------------------------------- FSM: outputs
  // in_ready never looks at in_data, so out_ready is the only input that
  // reaches it combinationally besides in_valid for the idle pick.
  always_comb begin
    in_ready = '0;
    if (reset && w_load && w_grant_live) begin
      in_ready[w_grant_idx] = 1'b1;
    end
  end

  assign locked = (r_state == ST_LOCKED);

  // ------------------------------------------------ output register and lock
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_sel     <= '0;
      r_lock_idx    <= '0;
      r_rr_ptr      <= '0;
      r_perf_stalls <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_grant_beat;
        r_out_sel   <= w_grant_idx;
        if (w_closing) begin
          r_rr_ptr <= w_ptr_next;
        end else begin
          r_lock_idx <= w_grant_idx;
        end
      end else if (w_load) begin
        r_out_valid <= 1'b0;
      end

      if (r_out_valid && !out_ready && (r_perf_stalls != '1)) begin
        r_perf_stalls <= r_perf_stalls + PERF_CTR_W'(1);
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_sel     = r_out_sel;
  assign perf_stalls = r_perf_stalls;

  // ------------------------------------------------------ protocol assertions
  // A new instruction may not start from the owner before it has closed.
  a_sop_in_lock : assert property (@(posedge clk) disable iff (!reset)
    !(locked && w_accept && w_grant_beat.sop));

  // Sources must hold a presented beat unchanged until it is taken.
  for (genvar i = 0; i < NUM_REQS; i++) begin : g_src_stable
    a_hold : assert property (@(posedge clk) disable iff (!reset)
      (in_valid[i] && !in_ready[i]) |=> (in_valid[i] && $stable(in_data[i])));
  end

endmodule
`default_nettype wire

// File: tb/tb_vx_commit_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_vx_commit_arb
// Description : Self-checking bench for vx_commit_arb: directed vector table,
//               hand-written multi-cycle sequences and a randomized run
//               against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vx_commit_arb;
  import vx_commit_arb_pkg::*;

  localparam int N  = 4;
  localparam int SW = 2;
  localparam int PW = 32;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N-1:0]          in_valid;
  commit_data_t [N-1:0]  in_data;
  logic [N-1:0]          in_ready;
  logic                  out_valid;
  commit_data_t          out_data;
  logic                  out_ready;
  logic [SW-1:0]         out_sel;
  logic                  locked;
  logic [PW-1:0]         perf_stalls;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vx_commit_arb #(.NUM_REQS(N), .PERF_CTR_W(PW)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .out_sel     (out_sel),
    .locked      (locked),
    .perf_stalls (perf_stalls)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic commit_data_t mk_beat(input int src, input logic sop, input logic eop,
                                           input logic vec, input logic vd);
    commit_data_t b;
    b            = '0;
    b.uuid       = 8'(src);
    b.wid        = 2'(src);
    b.pc         = 32'h1000 + 32'(src);
    b.sop        = sop;
    b.eop        = eop;
    b.is_vec     = vec;
    b.vd_is_last = vd;
    return b;
  endfunction

  task automatic set_src(input int s, input logic v, input logic sop, input logic eop,
                         input logic vec, input logic vd);
    in_valid[s] = v;
    in_data[s]  = mk_beat(s, sop, eop, vec, vd);
  endtask

  task automatic clear_inputs();
    in_valid = '0;
    for (int s = 0; s < N; s++) in_data[s] = '0;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    out_ready = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Advance one clock and return at posedge+1 for output sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------------------ vector table
  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] sop;
    logic [N-1:0] eop;
    logic         ordy;
    logic [N-1:0] exp_rdy;
    logic         exp_ov;
    int           exp_sel;
    logic         exp_lock;
  } vec_t;

  vec_t tbl[9];

  // --------------------------------------------------------- random model
  bit           pend[N];
  bit           vec_tx[N];
  int           pos[N];
  int           len[N];
  commit_data_t cur[N];

  function automatic commit_data_t gen_beat(input int s, input int p, input int l, input bit v);
    commit_data_t b;
    b        = '0;
    b.uuid   = 8'($urandom);
    b.wid    = 2'(s);
    b.tmask  = 2'($urandom);
    b.pc     = $urandom;
    b.wb     = 1'($urandom);
    b.rd     = 5'($urandom);
    b.data   = {$urandom, $urandom};
    b.pid    = 1'($urandom);
    b.sop    = (p == 0);
    b.is_vec = v;
    if (v) begin
      b.eop        = 1'b1;
      b.vd_is_last = (p == l - 1);
    end else begin
      b.eop        = (p == l - 1);
      b.vd_is_last = 1'($urandom);
    end
    return b;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    out_ready = 1'b1;
    clear_inputs();

    // valid   sop     eop     ordy  exp_rdy ov sel lock
    tbl[0] = '{4'b0101, 4'b0101, 4'b0001, 1'b1, 4'b0001, 1'b1, 0, 1'b0};
    tbl[1] = '{4'b0101, 4'b0101, 4'b0001, 1'b1, 4'b0100, 1'b1, 2, 1'b1};
    tbl[2] = '{4'b0101, 4'b0001, 4'b0001, 1'b1, 4'b0100, 1'b1, 2, 1'b1};
    tbl[3] = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 4'b0100, 1'b0, 2, 1'b1};
    tbl[4] = '{4'b0101, 4'b0001, 4'b0101, 1'b1, 4'b0100, 1'b1, 2, 1'b0};
    tbl[5] = '{4'b0001, 4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b1, 2, 1'b0};
    tbl[6] = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 0, 1'b0};
    tbl[7] = '{4'b1000, 4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b1, 3, 1'b0};
    tbl[8] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 3, 1'b0};

    // --------------------------------------------------- reset state
    do_reset();
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_locked", 128'(locked), 128'(0));
    chk("rst_out_sel", 128'(out_sel), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_perf_stalls", 128'(perf_stalls), 128'(0));

    // --------------------------------------------------- table
    for (int r = 0; r < 9; r++) begin
      out_ready = tbl[r].ordy;
      for (int s = 0; s < N; s++)
        set_src(s, tbl[r].valid[s], tbl[r].sop[s], tbl[r].eop[s], 1'b0, 1'b0);
      #1;
      chk($sformatf("tbl%0d_in_ready", r), 128'(in_ready), 128'(tbl[r].exp_rdy));
      step();
      chk($sformatf("tbl%0d_out_valid", r), 128'(out_valid), 128'(tbl[r].exp_ov));
      chk($sformatf("tbl%0d_out_sel", r), 128'(out_sel), 128'(tbl[r].exp_sel));
      chk($sformatf("tbl%0d_locked", r), 128'(locked), 128'(tbl[r].exp_lock));
      if (tbl[r].exp_ov)
        chk($sformatf("tbl%0d_uuid", r), 128'(out_data.uuid), 128'(tbl[r].exp_sel));
    end

    // --------------------------------------------------- round-robin fairness
    do_reset();
    for (int s = 0; s < N; s++) set_src(s, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("rr%0d_in_ready", k), 128'(in_ready), 128'(1 << (k % N)));
      step();
      chk($sformatf("rr%0d_out_valid", k), 128'(out_valid), 128'(1));
      chk($sformatf("rr%0d_out_sel", k), 128'(out_sel), 128'(k % N));
    end

    // --------------------------------------------------- vector lock
    do_reset();
    set_src(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    set_src(0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    chk("vec0_sel", 128'(out_sel), 128'(0));
    chk("vec0_locked", 128'(locked), 128'(1));
    set_src(0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    chk("vec1_sel", 128'(out_sel), 128'(0));
    chk("vec1_locked", 128'(locked), 128'(1));
    set_src(0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    chk("vec2_sel", 128'(out_sel), 128'(0));
    chk("vec2_locked", 128'(locked), 128'(0));
    set_src(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk("vec3_sel_after_ptr", 128'(out_sel), 128'(1));

    // --------------------------------------------------- backpressure
    do_reset();
    set_src(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk("bp_first_sel", 128'(out_sel), 128'(1));
    set_src(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_src(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    set_src(2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp%0d_in_ready", k), 128'(in_ready), 128'(0));
      step();
      chk($sformatf("bp%0d_out_valid", k), 128'(out_valid), 128'(1));
      chk($sformatf("bp%0d_out_data", k), 128'(out_data), 128'(mk_beat(1, 1'b1, 1'b1, 1'b0, 1'b0)));
    end
    chk("bp_perf_stalls", 128'(perf_stalls), 128'(5));
    out_ready = 1'b1;
    step();
    chk("bp_release_sel", 128'(out_sel), 128'(2));
    chk("bp_perf_hold", 128'(perf_stalls), 128'(5));

    // --------------------------------------------------- reset mid-transaction
    do_reset();
    set_src(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("rm_locked", 128'(locked), 128'(1));
    set_src(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    set_src(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    set_src(3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    out_ready = 1'b0;
    step();
    chk("rm_stall", 128'(perf_stalls), 128'(1));
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rm_in_ready_in_reset", 128'(in_ready), 128'(0));
    step();
    chk("rm_locked_clr", 128'(locked), 128'(0));
    chk("rm_out_valid_clr", 128'(out_valid), 128'(0));
    chk("rm_perf_clr", 128'(perf_stalls), 128'(0));
    reset = 1'b1;
    set_src(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rm_first_ready", 128'(in_ready), 128'(4'b0010));
    step();
    chk("rm_first_sel", 128'(out_sel), 128'(1));

    // --------------------------------------------------- randomized run
    do_reset();
    begin
      int           owner;
      int           ptr;
      logic         m_ov;
      commit_data_t m_data;
      int           m_sel;
      logic [PW-1:0] m_stalls;
      logic         load;
      int           g;
      int           g_rdy;
      logic [N-1:0] exp_rdy;
      owner    = -1;
      ptr      = 0;
      m_ov     = 1'b0;
      m_data   = '0;
      m_sel    = 0;
      m_stalls = '0;
      for (int s = 0; s < N; s++) begin
        pend[s] = 0; pos[s] = 0; len[s] = 1; vec_tx[s] = 0; cur[s] = '0;
      end
      for (int cyc = 0; cyc < 400; cyc++) begin
        for (int s = 0; s < N; s++) begin
          if (!pend[s]) begin
            if (pos[s] != 0) begin
              if ($urandom_range(0, 9) < 7) begin
                cur[s]  = gen_beat(s, pos[s], len[s], vec_tx[s]);
                pend[s] = 1;
              end
            end else if ($urandom_range(0, 1) == 1) begin
              len[s]    = $urandom_range(1, 4);
              vec_tx[s] = ($urandom_range(0, 3) == 0);
              cur[s]    = gen_beat(s, 0, len[s], vec_tx[s]);
              pend[s]   = 1;
            end
          end
          in_valid[s] = pend[s];
          in_data[s]  = pend[s] ? cur[s] : gen_beat(s, 1, 3, 1'b0);
        end
        out_ready = ($urandom_range(0, 3) != 0);

        load  = !m_ov || out_ready;
        g     = -1;
        g_rdy = -1;
        if (owner >= 0) begin
          g_rdy = owner;
          if (pend[owner]) g = owner;
        end else begin
          for (int k = 0; k < N; k++) begin
            if (g < 0 && pend[(ptr + k) % N]) g = (ptr + k) % N;
          end
          g_rdy = g;
        end
        exp_rdy = '0;
        if (load && g_rdy >= 0) exp_rdy[g_rdy] = 1'b1;
        #1;
        chk("rnd_in_ready", 128'(in_ready), 128'(exp_rdy));
        step();

        if (m_ov && !out_ready && m_stalls != '1) m_stalls = m_stalls + 1;
        if (load && g >= 0) begin
          m_ov   = 1'b1;
          m_data = cur[g];
          m_sel  = g;
          if (pos[g] == len[g] - 1) begin
            owner  = -1;
            ptr    = (g + 1) % N;
            pos[g] = 0;
          end else begin
            owner  = g;
            pos[g] = pos[g] + 1;
          end
          pend[g] = 0;
        end else if (load) begin
          m_ov = 1'b0;
        end

        chk("rnd_out_valid", 128'(out_valid), 128'(m_ov));
        if (m_ov) begin
          chk("rnd_out_data", 128'(out_data), 128'(m_data));
          chk("rnd_out_sel", 128'(out_sel), 128'(m_sel));
        end
        chk("rnd_locked", 128'(locked), 128'(owner >= 0));
        chk("rnd_perf_stalls", 128'(perf_stalls), 128'(m_stalls));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vx_commit_arb.md
# VX_commit_arb

Merges commit streams from `NUM_REQS` execution units (ALU, LSU, FPU, SFU, VPU) into the single commit port that feeds writeback and the scoreboard release. Arbitration is round-robin. A grant is locked for the full multi-beat transaction (`sop`…`eop`), and for vector ops until the last destination lane, so beats of one instruction are never interleaved. The output is registered and runs at full throughput.

## Interface
Parameters:
- `NUM_REQS`, 4: number of upstream commit sources (1..16).
- `NUM_LANES`, `NUM_THREADS`: lanes per commit beat; sets `commit_data_t` width.
- `PERF_CTR_W`, 32: width of the stall counter.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-low.
- `in_valid`  in  NUM_REQS  per-source beat valid.
- `in_data`  in  NUM_REQS × `commit_data_t`  per-source beat.
- `in_ready`  out  NUM_REQS  per-source accept.
- `out_valid`  out  1  registered beat valid.
- `out_data`  out  `commit_data_t`  registered beat.
- `out_ready`  in  1  downstream accept.
- `out_sel`  out  `LOG2UP(NUM_REQS)`  source index of the current `out_data`.
- `locked`  out  1  a transaction is in progress (`sop` accepted, closing beat not yet accepted).
- `perf_stalls`  out  PERF_CTR_W  saturating count of cycles with `out_valid && !out_ready`.

## Operation
- **Closing beat:** a beat with `eop && (!is_vec || vd_is_last)`. Without `EXT_V_ENABLE`, this reduces to `eop`.
- **Load enable:** `load = !out_valid || out_ready`.
- **IDLE state (`locked`=0):**
  - Candidates are all sources with `in_valid`.
  - Winner is the first candidate at or after `rr_ptr`, scanning upward with wrap.
  - `in_ready[winner] = load`. All other `in_ready` are 0.
- **LOCKED state (`locked`=1):**
  - Only `lock_idx` is eligible, with `in_ready[lock_idx] = load`.
  - Other sources wait, even if `lock_idx` has `in_valid`=0 (bubble). The lock is held through bubbles.
- **Accepted beat** (`in_valid[g] && in_ready[g]`):
  - Register `out_data <= in_data[g]`, `out_sel <= g`, `out_valid <= 1`.
  - If the beat is not closing: `locked <= 1`, `lock_idx <= g`.
  - If the beat is closing: `locked <= 0`, `rr_ptr <= (g+1) mod NUM_REQS`.
- **Single-beat op** (`sop`=`eop`=1, non-vector or `vd_is_last`=1): never sets the lock. The pointer still advances.
- **No accept while `load`=1:** `out_valid <= 0`.
- **Stall counter:** `perf_stalls` increments when `out_valid && !out_ready` and holds at all-ones.
- **Protocol error:** a beat with `sop`=1 accepted from `lock_idx` while locked is a simulation assertion (`VX_ASSERT`). Hardware treats it as a continuation.
- **Source-side rule:** `in_valid`/`in_data` must stay stable until accepted. This is asserted in simulation.
- **`NUM_REQS`=1:** the arbiter degenerates to a registered pipe. The lock logic is retained; `out_sel` is 0.

## Timing
- **Latency:** 1 cycle from accept to `out_valid`. Throughput is 1 beat per cycle with back-to-back beats when `out_ready`=1.
- **Combinational paths:** `in_ready` depends on `out_ready` (single combinational path). There is no path from `in_data` to any output.
- **Reset values:** `out_valid`=0, `out_data`=0, `out_sel`=0, `locked`=0, `lock_idx`=0, `rr_ptr`=0, `perf_stalls`=0. `in_ready`=0 during reset.
- **Reset mid-transaction:** the lock clears and the buffered beat is dropped. The next cycle after deassertion is IDLE with `rr_ptr`=0.
- **Simultaneous close and request:** a closing beat from g with another source requesting in the same cycle means that source can win on the next cycle. No dead cycle is inserted.
- **Pointer wrap:** a closing beat from `NUM_REQS-1` sets `rr_ptr`=0.
- **Output stall:** with `out_ready`=0 and `out_valid`=1, all `in_ready`=0 and state is frozen.

## Structure
- Shared package (`VX_gpu_pkg`):
  - `commit_data_t`: the uuid/wid/tmask/PC/wb/rd/data/pid/sop/eop struct, plus the vector fields under `EXT_V_ENABLE`.
  - `is_closing_beat()` function.
- Sub-module: `VX_rr_picker`, a combinational round-robin find-first from `rr_ptr` that returns index and valid. It is reusable by the issue dispatcher.
- All state lives in `VX_commit_arb`: the lock FSM, output register and counter.

## Test plan
- **Round-robin fairness:** `NUM_REQS`=4, all sources send single-beat ops continuously with `out_ready`=1 → `out_sel` sequence 0,1,2,3,0,1…, one beat per cycle.
- **Multi-beat lock:** source 2 sends 3 beats (sop, –, eop) while source 0 is valid throughout → `out_sel` = 2,2,2,0. `locked`=1 for 2 cycles.
- **Lock through bubble:** source 1 sends sop, then drops `in_valid` for 2 cycles, then sends eop; source 3 is valid throughout → `out_valid`=0 during the bubble and source 3 gets no grant until after the eop.
- **Vector lock:** source 0 sends `is_vec`=1 beats with `eop`=1 but `vd_is_last`=0, then one beat with `vd_is_last`=1 → lock held until the final beat, then `rr_ptr`=1.
- **Backpressure:** hold `out_ready`=0 for 5 cycles with `out_valid`=1 → `out_data` stable, all `in_ready`=0, `perf_stalls`=5.
- **Reset mid-transaction:** drive `reset`=0 while locked on source 2 → next cycle `locked`=0, `out_valid`=0, `perf_stalls`=0. The first grant after reset goes to the lowest valid index.
